// File: rtl/prirv32_lsu.sv
// prirv32_lsu: RV32I load/store unit. Accepts one EXU memory op at a time,
// issues a single word-aligned bus access and writes load results back.
// Ports:
//   clk_i, rst_n                  clock, async active-low reset
//   req_*                         EXU request (valid/ready, we, funct3,
//                                 addr, wdata, rd)
//   mem_req_o/we/addr/be/wdata    bus request, held until mem_gnt_i
//   mem_gnt_i/rvalid_i/rdata_i    bus grant and read response
//   wb_we_o/waddr_o/wdata_o       register-file write port
//   err_bus_o, err_misalign_o     one-cycle error pulses
// Parameter BUS_TIMEOUT: cycles allowed in REQ or WAIT (0 disables).
// Optional macro PRIRV32_LSU_MISALIGN_TRAP_EN: misaligned H/W requests
// are rejected with err_misalign_o instead of having low bits cleared.
module prirv32_lsu #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_we_o,
    output logic [4:0]  wb_waddr_o,
    output logic [31:0] wb_wdata_o,
    output logic        err_bus_o,
    output logic        err_misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_waddr_q, wb_waddr_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic        err_bus_q, err_bus_d;

    logic        in_b, in_h, in_w;
    logic [1:0]  in_off;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic        ld_b, ld_h, ld_w;
    logic [31:0] ld_shift;
    logic [31:0] ld_data;
    logic        tmo_hit;
    logic        trap_take;

    // Size decode: funct3[1:0] 00=B, 01=H, 1x=W.
    assign in_b = (req_funct3_i[1:0] == 2'b00);
    assign in_h = (req_funct3_i[1:0] == 2'b01);
    assign in_w = req_funct3_i[1];

    // Offset with misaligned low bits dropped.
    always_comb begin
        in_off = req_addr_i[1:0];
        if (in_h) in_off[0] = 1'b0;
        if (in_w) in_off    = 2'b00;
    end

    always_comb begin
        st_be   = 4'b1111;
        st_data = req_wdata_i;
        unique case (1'b1)
            in_b: begin
                st_be   = 4'b0001 << in_off;
                st_data = {4{req_wdata_i[7:0]}};
            end
            in_h: begin
                st_be   = 4'b0011 << {in_off[1], 1'b0};
                st_data = {2{req_wdata_i[15:0]}};
            end
            in_w: begin
                st_be   = 4'b1111;
                st_data = req_wdata_i;
            end
            default: ;
        endcase
    end

    assign ld_b     = (f3_q[1:0] == 2'b00);
    assign ld_h     = (f3_q[1:0] == 2'b01);
    assign ld_w     = f3_q[1];
    assign ld_shift = mem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        ld_data = mem_rdata_i;
        unique case (1'b1)
            ld_b: ld_data = f3_q[2]
                ? {24'h0, ld_shift[7:0]}
                : {{24{ld_shift[7]}}, ld_shift[7:0]};
            ld_h: ld_data = f3_q[2]
                ? {16'h0, ld_shift[15:0]}
                : {{16{ld_shift[15]}}, ld_shift[15:0]};
            ld_w: ld_data = mem_rdata_i;
            default: ;
        endcase
    end

`ifdef PRIRV32_LSU_MISALIGN_TRAP_EN
    logic in_mis;
    logic err_mis_q;

    assign in_mis = (in_h & req_addr_i[0])
                  | (in_w & (req_addr_i[1:0] != 2'b00));
    assign trap_take = (state_q == S_IDLE)
                     & req_valid_i & in_mis;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) err_mis_q <= 1'b0;
        else        err_mis_q <= trap_take;
    end

    assign err_misalign_o = err_mis_q;
`else
    assign trap_take      = 1'b0;
    assign err_misalign_o = 1'b0;
`endif

    // Abort on the edge where the cycle count would reach the limit.
    assign tmo_hit = (BUS_TIMEOUT != 0)
                   && ((cnt_q + 32'd1) == 32'(BUS_TIMEOUT));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 32'd1;
        we_d        = we_q;
        f3_d        = f3_q;
        off_d       = off_q;
        rd_d        = rd_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wb_we_d     = 1'b0;
        wb_waddr_d  = wb_waddr_q;
        wb_wdata_d  = wb_wdata_q;
        err_bus_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = 32'd0;
                if (req_valid_i && !trap_take) begin
                    we_d        = req_we_i;
                    f3_d        = req_funct3_i;
                    off_d       = in_off;
                    rd_d        = req_rd_i;
                    mem_we_d    = req_we_i;
                    mem_addr_d  = {req_addr_i[31:2], 2'b00};
                    mem_be_d    = st_be;
                    mem_wdata_d = st_data;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    cnt_d   = 32'd0;
                    state_d = we_q ? S_IDLE : S_WAIT;
                end else if (tmo_hit) begin
                    err_bus_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    wb_we_d    = (rd_q != 5'd0);
                    wb_waddr_d = rd_q;
                    wb_wdata_d = ld_data;
                    state_d    = S_IDLE;
                end else if (tmo_hit) begin
                    err_bus_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 32'd0;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            rd_q        <= 5'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            wb_we_q     <= 1'b0;
            wb_waddr_q  <= 5'd0;
            wb_wdata_q  <= 32'd0;
            err_bus_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            wb_we_q     <= wb_we_d;
            wb_waddr_q  <= wb_waddr_d;
            wb_wdata_q  <= wb_wdata_d;
            err_bus_q   <= err_bus_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign mem_req_o   = (state_q == S_REQ);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;
    assign wb_we_o     = wb_we_q;
    assign wb_waddr_o  = wb_waddr_q;
    assign wb_wdata_o  = wb_wdata_q;
    assign err_bus_o   = err_bus_q;

endmodule

// File: tb/tb_prirv32_lsu.sv
// tb_prirv32_lsu: randomized and directed checks of prirv32_lsu against
// a transaction-level reference model of loads, stores and timeouts.
module tb_prirv32_lsu;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        wb_we_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        err_bus_o;
    logic        err_misalign_o;

    int errors = 0;
    int checks = 0;

    prirv32_lsu #(.BUS_TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_rd_i(req_rd_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i),
        .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o),
        .wb_wdata_o(wb_wdata_o),
        .err_bus_o(err_bus_o), .err_misalign_o(err_misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: plain byte arithmetic on access size and offset.
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3,
            input int off, input logic [31:0] rdata);
        longint v, full, half;
        int sz;
        sz   = size_of(f3);
        full = longint'(1) << (8 * sz);
        half = full / 2;
        v = (longint'(rdata) >> (8 * off)) % full;
        if (!f3[2] && sz < 4 && v >= half) v = v - full;
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3,
                                        input int off);
        int sz;
        sz = size_of(f3);
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                            input logic [31:0] wd);
        longint v, acc, full;
        int sz;
        sz   = size_of(f3);
        full = longint'(1) << (8 * sz);
        v    = longint'(wd) % full;
        acc  = 0;
        for (int i = 0; i < 4 / sz; i++) acc = acc + (v << (8 * sz * i));
        return acc[31:0];
    endfunction

    task automatic idle_bus();
        req_valid_i  = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
    endtask

    // One complete transaction with the given bus delays.
    task automatic do_op(input string tg, input logic we,
            input logic [2:0] f3, input logic [31:0] addr,
            input logic [31:0] wd, input logic [4:0] rd,
            input int gd, input int rvd, input logic [31:0] rdata);
        int sz, off;
        logic [31:0] ea;
        bit mis;
        sz  = size_of(f3);
        mis = (addr % sz) != 0;
        ea  = addr - (addr % sz);
        off = int'(ea % 4);
        chk({tg, ":ready0"}, 32'(req_ready_o), 32'd1);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wd;
        req_rd_i     = rd;
        step();
        req_valid_i = 1'b0;
`ifdef PRIRV32_LSU_MISALIGN_TRAP_EN
        if (mis) begin
            chk({tg, ":mis_err"}, 32'(err_misalign_o), 32'd1);
            chk({tg, ":mis_req"}, 32'(mem_req_o), 32'd0);
            chk({tg, ":mis_rdy"}, 32'(req_ready_o), 32'd1);
            step();
            chk({tg, ":mis_clr"}, 32'(err_misalign_o), 32'd0);
            chk({tg, ":mis_req2"}, 32'(mem_req_o), 32'd0);
            return;
        end
`else
        if (mis) chk({tg, ":nomis_err"}, 32'(err_misalign_o), 32'd0);
`endif
        for (int k = 0; k <= gd; k++) begin
            chk({tg, ":req"}, 32'(mem_req_o), 32'd1);
            chk({tg, ":addr"}, mem_addr_o, {ea[31:2], 2'b00});
            chk({tg, ":we"}, 32'(mem_we_o), 32'(we));
            chk({tg, ":rdy_req"}, 32'(req_ready_o), 32'd0);
            if (we) begin
                chk({tg, ":be"}, 32'(mem_be_o), 32'(m_be(f3, off)));
                chk({tg, ":wd"}, mem_wdata_o, m_wdata(f3, wd));
            end
            mem_gnt_i    = (k == gd);
            mem_rvalid_i = 1'($urandom_range(0, 1));
            mem_rdata_i  = $urandom;
            step();
            idle_bus();
        end
        chk({tg, ":req_off"}, 32'(mem_req_o), 32'd0);
        if (we) begin
            chk({tg, ":st_rdy"}, 32'(req_ready_o), 32'd1);
            chk({tg, ":st_wb"}, 32'(wb_we_o), 32'd0);
            return;
        end
        for (int k = 0; k <= rvd; k++) begin
            chk({tg, ":wait_rdy"}, 32'(req_ready_o), 32'd0);
            chk({tg, ":wait_wb"}, 32'(wb_we_o), 32'd0);
            mem_gnt_i    = 1'($urandom_range(0, 1));
            mem_rvalid_i = (k == rvd);
            mem_rdata_i  = (k == rvd) ? rdata : $urandom;
            step();
            idle_bus();
        end
        chk({tg, ":wb_we"}, 32'(wb_we_o), 32'(rd != 5'd0));
        chk({tg, ":ld_rdy"}, 32'(req_ready_o), 32'd1);
        if (rd != 5'd0) begin
            chk({tg, ":wb_rd"}, 32'(wb_waddr_o), 32'(rd));
            chk({tg, ":wb_data"}, wb_wdata_o, m_load(f3, off, rdata));
        end
        step();
        chk({tg, ":wb_pulse"}, 32'(wb_we_o), 32'd0);
    endtask

    initial begin
        logic [2:0] f3;
        rst_n        = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = 3'd0;
        req_addr_i   = 32'd0;
        req_wdata_i  = 32'd0;
        req_rd_i     = 5'd0;
        mem_rdata_i  = 32'd0;
        idle_bus();
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst:ready", 32'(req_ready_o), 32'd1);
        chk("rst:req", 32'(mem_req_o), 32'd0);
        chk("rst:addr", mem_addr_o, 32'd0);
        chk("rst:be", 32'(mem_be_o), 32'd0);
        chk("rst:wb", 32'(wb_we_o), 32'd0);
        chk("rst:ebus", 32'(err_bus_o), 32'd0);
        chk("rst:emis", 32'(err_misalign_o), 32'd0);

        do_op("lb103", 1'b0, 3'b000, 32'h103, 32'h0, 5'd5,
              0, 0, 32'h80FF_FF12);
        chk("lb103:lit", wb_wdata_o, 32'hFFFF_FF80);
        do_op("sh202", 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 5'd0,
              0, 0, 32'h0);
        do_op("stall", 1'b0, 3'b010, 32'h340, 32'h0, 5'd9,
              3, 0, 32'hDEAD_BEEF);
        do_op("lw6", 1'b0, 3'b010, 32'h6, 32'h0, 5'd7,
              0, 1, 32'h1234_5678);
        do_op("lhu", 1'b0, 3'b101, 32'h12, 32'h0, 5'd3,
              1, 2, 32'h8765_4321);
        do_op("rd0", 1'b0, 3'b000, 32'h1, 32'h0, 5'd0,
              0, 0, 32'hFFFF_FFFF);

        // Load with no read response: abort after TMO cycles in WAIT.
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b010;
        req_addr_i   = 32'h80;
        req_rd_i     = 5'd4;
        step();
        req_valid_i = 1'b0;
        mem_gnt_i   = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            chk("tmo_w:busy", 32'(req_ready_o), 32'd0);
            chk("tmo_w:err", 32'(err_bus_o), 32'd0);
            step();
        end
        chk("tmo_w:pulse", 32'(err_bus_o), 32'd1);
        chk("tmo_w:ready", 32'(req_ready_o), 32'd1);
        chk("tmo_w:wb", 32'(wb_we_o), 32'd0);
        step();
        chk("tmo_w:clr", 32'(err_bus_o), 32'd0);
        chk("tmo_w:wb2", 32'(wb_we_o), 32'd0);

        // Store never granted: request held TMO cycles, then dropped.
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = 3'b010;
        req_addr_i   = 32'h44;
        step();
        req_valid_i = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            chk("tmo_r:req", 32'(mem_req_o), 32'd1);
            step();
        end
        chk("tmo_r:pulse", 32'(err_bus_o), 32'd1);
        chk("tmo_r:req_off", 32'(mem_req_o), 32'd0);
        chk("tmo_r:ready", 32'(req_ready_o), 32'd1);
        step();

        // Reset while waiting for read data drops the load.
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b010;
        req_addr_i   = 32'h100;
        req_rd_i     = 5'd8;
        step();
        req_valid_i = 1'b0;
        mem_gnt_i   = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        chk("rstw:busy", 32'(req_ready_o), 32'd0);
        rst_n = 1'b0;
        #2;
        chk("rstw:idle", 32'(req_ready_o), 32'd1);
        step();
        rst_n        = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_F00D;
        step();
        mem_rvalid_i = 1'b0;
        chk("rstw:wb", 32'(wb_we_o), 32'd0);
        chk("rstw:ready", 32'(req_ready_o), 32'd1);
        chk("rstw:req", 32'(mem_req_o), 32'd0);
        step();
        chk("rstw:wb2", 32'(wb_we_o), 32'd0);

        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            do_op("rnd", 1'($urandom_range(0, 1)), f3,
                  {22'($urandom), 10'($urandom)},
                  $urandom, 5'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
